// File: rtl/ppu_row_buffer_if.sv
// Display/renderer side of the row-RAM link: read port, frame strobes, render request and write port.
// Pure wiring; no flow control beyond the one-cycle strobes and row_req/row_done pairing.
interface ppu_row_buffer_if;
   logic [8:0] rowram_rdaddr;
   logic [9:0] rowram_rddata;
   logic       rowram_swap;
   logic       vblank_start;
   logic       vblank_end;
   logic       row_req;
   logic [7:0] row_num;
   logic       wr_en;
   logic [8:0] wr_addr;
   logic [9:0] wr_data;
   logic       row_done;
   logic       underrun;

   // master: display timing + renderer; slave: the PPU row buffer
   modport master (
      output rowram_rdaddr, rowram_swap, vblank_start, vblank_end,
             wr_en, wr_addr, wr_data, row_done,
      input  rowram_rddata, row_req, row_num, underrun
   );

   modport slave (
      input  rowram_rdaddr, rowram_swap, vblank_start, vblank_end,
             wr_en, wr_addr, wr_data, row_done,
      output rowram_rddata, row_req, row_num, underrun
   );
endinterface

// File: rtl/ppu_row_buffer.sv
// Double-buffered 320x10 row RAM: registered front-buffer reads (1 cycle), back-buffer renderer writes.
// No backpressure: swaps flip line-doubled buffers regardless of render progress and flag underrun instead.
module ppu_row_buffer #(
   parameter int ROW_WIDTH   = 320,
   parameter int ROWS        = 240,
   parameter int LINE_REPEAT = 2
) (
   input  logic               video_clk,
   input  logic               rst_n,
   ppu_row_buffer_if.slave    bus
);

   localparam int REP_W = (LINE_REPEAT > 1) ? $clog2(LINE_REPEAT) : 1;
   localparam logic [8:0]       ROW_WIDTH_L = 9'(ROW_WIDTH);
   localparam logic [7:0]       ROWS_L      = 8'(ROWS);
   localparam logic [REP_W-1:0] REP_LAST    = REP_W'(LINE_REPEAT - 1);

   typedef enum logic [1:0] {F_IDLE, F_PRIME, F_ACTIVE} frame_e;
   typedef enum logic [1:0] {B_EMPTY, B_RENDER, B_READY} back_e;

   frame_e           frame_q, frame_d;
   back_e            back_q, back_d, back_eff;
   logic             front_sel_q, front_sel_d;
   logic             skip_q, skip_d;
   logic [REP_W-1:0] rep_q, rep_d;
   logic [7:0]       next_row_q, next_row_d;
   logic             row_req_q, row_req_d;
   logic [7:0]       row_num_q, row_num_d;
   logic             underrun_q, underrun_d;
   logic [9:0]       rddata_q, rddata_d;
   logic             flip;

   logic [9:0] mem_q [2][ROW_WIDTH];

   always_comb begin
      rddata_d = '0;
      if (bus.rowram_rdaddr < ROW_WIDTH_L) begin
         rddata_d = mem_q[front_sel_q][bus.rowram_rdaddr];
      end
   end

   // Back buffer is the one not being displayed; only the active render may write it.
   always_ff @(posedge video_clk) begin
      if (rst_n && bus.wr_en && back_q == B_RENDER && bus.wr_addr < ROW_WIDTH_L) begin
         mem_q[~front_sel_q][bus.wr_addr] <= bus.wr_data;
      end
   end

   always_comb begin
      frame_d     = frame_q;
      front_sel_d = front_sel_q;
      skip_d      = skip_q;
      rep_d       = rep_q;
      next_row_d  = next_row_q;
      row_req_d   = 1'b0;
      row_num_d   = row_num_q;
      underrun_d  = underrun_q;
      flip        = 1'b0;
      // row_done lands before any same-cycle flip so a just-finished row counts as ready
      back_eff    = (back_q == B_RENDER && bus.row_done) ? B_READY : back_q;
      back_d      = back_eff;

      if (bus.vblank_end) begin
         frame_d    = F_PRIME;
         row_req_d  = 1'b1;
         row_num_d  = '0;
         back_d     = B_RENDER;
         next_row_d = 8'd1;
         skip_d     = 1'b1;
         rep_d      = '0;
      end else if (bus.vblank_start && frame_q != F_IDLE) begin
         frame_d = F_IDLE;
         back_d  = B_EMPTY;
      end else if (bus.rowram_swap) begin
         case (frame_q)
            F_PRIME: begin
               if (skip_q) begin
                  skip_d  = 1'b0;
                  frame_d = F_ACTIVE;
               end
            end
            F_ACTIVE: begin
               if (rep_q != '0) begin
                  rep_d = rep_q - REP_W'(1);
               end else begin
                  flip = 1'b1;
               end
            end
            default: ;
         endcase
      end

      if (flip) begin
         front_sel_d = ~front_sel_q;
         rep_d       = REP_LAST;
         if (back_eff != B_READY) begin
            underrun_d = 1'b1;
         end
         if (next_row_q < ROWS_L) begin
            row_req_d  = 1'b1;
            row_num_d  = next_row_q;
            next_row_d = next_row_q + 8'd1;
            back_d     = B_RENDER;
         end else begin
            back_d = B_EMPTY;
         end
      end
   end

   always_ff @(posedge video_clk) begin
      if (!rst_n) begin
         frame_q     <= F_IDLE;
         back_q      <= B_EMPTY;
         front_sel_q <= 1'b0;
         skip_q      <= 1'b0;
         rep_q       <= '0;
         next_row_q  <= '0;
         row_req_q   <= 1'b0;
         row_num_q   <= '0;
         underrun_q  <= 1'b0;
         rddata_q    <= '0;
      end else begin
         frame_q     <= frame_d;
         back_q      <= back_d;
         front_sel_q <= front_sel_d;
         skip_q      <= skip_d;
         rep_q       <= rep_d;
         next_row_q  <= next_row_d;
         row_req_q   <= row_req_d;
         row_num_q   <= row_num_d;
         underrun_q  <= underrun_d;
         rddata_q    <= rddata_d;
      end
   end

   assign bus.rowram_rddata = rddata_q;
   assign bus.row_req       = row_req_q;
   assign bus.row_num       = row_num_q;
   assign bus.underrun      = underrun_q;

endmodule

// File: tb/tb_ppu_row_buffer.sv
// Scoreboard bench for ppu_row_buffer: expected row requests and read data are queued as stimulus is
// driven and popped when the DUT presents them; a two-buffer model tracks what the front should hold.
module tb_ppu_row_buffer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ppu_row_buffer_if bus();

   ppu_row_buffer #(
      .ROW_WIDTH   (320),
      .ROWS        (240),
      .LINE_REPEAT (2)
   ) dut (
      .video_clk (clk),
      .rst_n     (rst_n),
      .bus       (bus.slave)
   );

   int n_cmp  = 0;
   int n_bad  = 0;
   int n_req  = 0;
   int n_push = 0;

   int         req_q[$];
   logic [9:0] rd_q[$];
   logic [9:0] m_mem [2][320];
   bit         m_sel;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // every row_req pulse must match the oldest expected request; 999 can never match an 8-bit row
   always @(negedge clk) begin
      if (bus.row_req === 1'b1) begin
         int exp_row;
         n_req++;
         exp_row = (req_q.size() != 0) ? req_q.pop_front() : 999;
         chk("row_num", {24'd0, bus.row_num}, exp_row);
      end
   end

   task automatic wr(input int addr, input logic [9:0] data, input bit taken);
      bus.wr_en   = 1'b1;
      bus.wr_addr = 9'(addr);
      bus.wr_data = data;
      if (taken && addr < 320) m_mem[!m_sel][addr] = data;
      tick();
      bus.wr_en = 1'b0;
   endtask

   task automatic swap(input bit flip, input bit done, input int req_row);
      bus.rowram_swap = 1'b1;
      bus.row_done    = done;
      if (flip) m_sel = !m_sel;
      if (req_row >= 0) begin
         req_q.push_back(req_row);
         n_push++;
      end
      tick();
      bus.rowram_swap = 1'b0;
      bus.row_done    = 1'b0;
   endtask

   task automatic done_pulse();
      bus.row_done = 1'b1;
      tick();
      bus.row_done = 1'b0;
   endtask

   task automatic vb_end();
      bus.vblank_end = 1'b1;
      req_q.push_back(0);
      n_push++;
      tick();
      bus.vblank_end = 1'b0;
   endtask

   task automatic rd(input int addr);
      bus.rowram_rdaddr = 9'(addr);
      rd_q.push_back((addr < 320) ? m_mem[m_sel][addr] : 10'd0);
      tick();
      chk("rddata", {22'd0, bus.rowram_rddata}, {22'd0, rd_q.pop_front()});
   endtask

   function automatic logic [9:0] v_lo(input int r);
      return 10'(r * 5 + 7);
   endfunction

   function automatic logic [9:0] v_hi(input int r);
      return 10'(1000 - r * 3);
   endfunction

   initial begin
      bus.rowram_rdaddr = '0;
      bus.rowram_swap   = 1'b0;
      bus.vblank_start  = 1'b0;
      bus.vblank_end    = 1'b0;
      bus.wr_en         = 1'b0;
      bus.wr_addr       = '0;
      bus.wr_data       = '0;
      bus.row_done      = 1'b0;
      m_sel             = 1'b0;
      for (int b = 0; b < 2; b++)
         for (int a = 0; a < 320; a++) m_mem[b][a] = '0;

      rst_n = 1'b0;
      tick();
      tick();
      chk("rst_rddata",  {22'd0, bus.rowram_rddata}, 0);
      chk("rst_row_req", {31'd0, bus.row_req}, 0);
      chk("rst_row_num", {24'd0, bus.row_num}, 0);
      chk("rst_underrun", {31'd0, bus.underrun}, 0);
      rst_n = 1'b1;
      tick();

      // frame 1: full 240-row line-doubled frame
      vb_end();
      chk("req_hi", {31'd0, bus.row_req}, 1);
      tick();
      chk("req_lo", {31'd0, bus.row_req}, 0);
      for (int a = 0; a < 320; a++) wr(a, 10'(a), 1'b1);
      wr(400, 10'h2AA, 1'b0);
      swap(1'b0, 1'b0, -1);
      chk("prime_underrun", {31'd0, bus.underrun}, 0);
      done_pulse();
      swap(1'b1, 1'b0, 1);
      for (int a = 0; a < 320; a++) rd(a);
      rd(400);
      rd(511);

      for (int r = 1; r < 240; r++) begin
         wr(0, v_lo(r), 1'b1);
         wr(319, v_hi(r), 1'b1);
         if (r != 50) done_pulse();
         if (r == 10) wr(0, 10'h3FF, 1'b0);
         swap(1'b0, 1'b0, -1);
         swap(1'b1, (r == 50), (r < 239) ? r + 1 : -1);
         rd(0);
         rd(319);
      end
      chk("f1_underrun", {31'd0, bus.underrun}, 0);
      chk("f1_req_count", n_req, 240);
      chk("f1_row_num_hold", {24'd0, bus.row_num}, 239);

      // vblank: swaps ignored, writes dropped
      bus.vblank_start = 1'b1;
      tick();
      bus.vblank_start = 1'b0;
      swap(1'b0, 1'b0, -1);
      rd(0);
      wr(0, 10'h155, 1'b0);

      // frame 2: flip without row_done raises a sticky underrun
      vb_end();
      wr(5, 10'h0AB, 1'b1);
      swap(1'b0, 1'b0, -1);
      swap(1'b1, 1'b0, 1);
      chk("f2_underrun", {31'd0, bus.underrun}, 1);
      rd(0);
      rd(5);
      bus.vblank_start = 1'b1;
      swap(1'b0, 1'b0, -1);
      bus.vblank_start = 1'b0;
      rd(5);
      swap(1'b0, 1'b0, -1);
      rd(5);
      chk("vbs_underrun_sticky", {31'd0, bus.underrun}, 1);

      // frame 3: restarted by a second vblank_end, then reset at row 100
      vb_end();
      tick();
      vb_end();
      chk("f3_underrun_sticky", {31'd0, bus.underrun}, 1);
      swap(1'b0, 1'b0, -1);
      for (int r = 0; r < 100; r++) begin
         wr(0, 10'(r * 11 + 600), 1'b1);
         done_pulse();
         swap(1'b1, 1'b0, r + 1);
         rd(0);
         swap(1'b0, 1'b0, -1);
      end
      chk("f3_row_num", {24'd0, bus.row_num}, 100);
      chk("f3_underrun", {31'd0, bus.underrun}, 1);

      rst_n = 1'b0;
      tick();
      chk("mid_rst_rddata",   {22'd0, bus.rowram_rddata}, 0);
      chk("mid_rst_row_req",  {31'd0, bus.row_req}, 0);
      chk("mid_rst_row_num",  {24'd0, bus.row_num}, 0);
      chk("mid_rst_underrun", {31'd0, bus.underrun}, 0);
      rst_n = 1'b1;
      m_sel = 1'b0;
      repeat (3) swap(1'b0, 1'b0, -1);
      rd(0);
      vb_end();
      tick();
      chk("post_rst_underrun", {31'd0, bus.underrun}, 0);

      chk("req_leftover", req_q.size(), 0);
      chk("req_total", n_req, n_push);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ppu_row_buffer.md
Name: ppu_row_buffer

Overview:
- PPU-side responder for the display row-RAM interface.
- Holds two 320-entry row buffers (front and back) of 10-bit palette indices.
- Serves registered reads of the front buffer to the HDMI video output. Accepts renderer writes into the back buffer.
- Turns the per-line swap strobe and the vblank strobes into line-doubled buffer flips and per-row render requests (240 logical rows shown on 480 lines).

Parameters:
- ROW_WIDTH, 320, entries per row buffer; the read/write address range is 0..ROW_WIDTH-1.
- ROWS, 240, logical rows per frame.
- LINE_REPEAT, 2, display lines per logical row.

Ports:
- video_clk  input  1  pixel clock; the only clock.
- rst_n  input  1  synchronous active-low reset.
- rowram_rdaddr  input  9  display read address.
- rowram_rddata  output  10  front-buffer data: palette address [9:1], word select [0].
- rowram_swap  input  1  one-cycle per-line swap strobe from display.
- vblank_start  input  1  one-cycle strobe at the start of vertical blank.
- vblank_end  input  1  one-cycle strobe one line before the first visible line.
- row_req  output  1  one-cycle pulse: start rendering row_num into the back buffer.
- row_num  output  8  logical row being requested; held until the next request.
- wr_en  input  1  renderer write strobe.
- wr_addr  input  9  back-buffer write address.
- wr_data  input  10  back-buffer write data.
- row_done  input  1  one-cycle pulse: the back buffer is fully written.
- underrun  output  1  sticky: a flip occurred before row_done.

Behaviour:
- Reset (synchronous, rst_n low at a video_clk edge):
  - rowram_rddata=0, row_req=0, row_num=0, underrun=0.
  - front_sel=0, frame state IDLE, back state EMPTY, skip=0, rep=0, next_row=0.
  - Buffer RAM contents are not cleared.
  - Reset mid-frame abandons any render; normal operation resumes at the next vblank_end.
- Read path:
  - rowram_rddata <= front[rowram_rdaddr] every cycle, in every state; latency is 1 cycle.
  - rowram_rdaddr >= ROW_WIDTH returns 0.
- Write path:
  - wr_en writes the back buffer only while the back state is RENDER and wr_addr < ROW_WIDTH; all other writes are dropped.
  - row_done in RENDER moves the back state to READY; row_done in any other state is ignored.
- Frame FSM: IDLE -> PRIME -> ACTIVE -> IDLE.
  - IDLE: rowram_swap is ignored. vblank_end -> PRIME; pulse row_req with row_num=0; back state=RENDER; next_row=1; skip=1; rep=0.
  - PRIME: the first rowram_swap is discarded (it falls on the non-visible prep line) -> ACTIVE.
  - ACTIVE, on rowram_swap:
    - If rep != 0: rep <= rep-1, no flip (line repeat).
    - If rep == 0: flip (front_sel toggles); rep <= LINE_REPEAT-1.
  - On a flip:
    - If the back state was not READY, set underrun (sticky until reset); the partial row is still flipped.
    - If next_row < ROWS: pulse row_req with row_num=next_row; next_row++; back state=RENDER.
    - Otherwise back state=EMPTY and no request is issued.
  - vblank_start in PRIME or ACTIVE -> IDLE; back state=EMPTY.
- Simultaneous events:
  - vblank_start with rowram_swap in the same cycle: vblank_start wins; no flip.
  - vblank_end while not IDLE: treated as a fresh frame start (same actions as from IDLE).
  - row_done with a flipping rowram_swap in the same cycle: row_done is applied first, so no underrun.
  - wr_en in a flip cycle writes the pre-flip back buffer. A write in the same cycle as a new row_req is dropped, because the back state was not RENDER before the edge.
  - rowram_rdaddr during a flip cycle reads the pre-flip front buffer.
- Arithmetic: next_row is 8 bits and saturates at ROWS (no wrap); rep is clog2(LINE_REPEAT) bits.

Test Plan:
- Reset/read: pulse rst_n low, preload front via render of row 0 with wr_data=addr, flip. Then drive rowram_rdaddr 0..319 -> rowram_rddata equals addr one cycle later; rdaddr=400 -> 0.
- Frame start: vblank_end -> row_req=1 for exactly one cycle with row_num=0. First swap changes nothing; row_done then second swap -> front_sel toggles and row_req with row_num=1.
- Line doubling: 480 swaps with row_done between flips -> exactly 240 flips, row_num sequence 0..239, no request after row 239, underrun=0.
- Underrun: withhold row_done before a flipping swap -> flip still occurs, underrun=1 and stays 1 through vblank_start and the next frame until rst_n.
- Collisions: vblank_start with swap in the same cycle -> no flip, state IDLE. row_done with swap in the same cycle -> no underrun. wr_en during IDLE or READY -> buffer unchanged on readback.
- Mid-frame reset: assert rst_n low during ACTIVE at row 100 -> all outputs 0, swaps ignored until vblank_end, then row_req with row_num=0.
